pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Program-counter sequencer that replaces the fixed combinational jump-target LUT.
- Holds the PC register and a run-time-writable jump-target table of 2**A entries. Each entry is tagged absolute or PC-relative.
- Adds a call/return stack, stall and halt.
- Drives the instruction-ROM address; the fetch/decode stage feeds it the table index and the control strobes.

Parameters:
D, 12, PC and target width (bits)
A, 5, table index width; table depth = 2**A
RS, 4, return-stack depth (entries)

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
stall  in  1  hold PC and stack this cycle
halt_req  in  1  stop sequencing; sticky until reset
jump  in  1  taken branch/jump to table[addr]
call  in  1  push return address, then jump to table[addr]
ret  in  1  pop return address into PC
addr  in  A  table index for jump/call
wr_en  in  1  table write strobe
wr_addr  in  A  table write index
wr_target  in  D  target value (absolute address or two's-complement offset)
wr_rel  in  1  1 = relative entry, 0 = absolute entry
pc  out  D  current program counter
halted  out  1  halt latched
rs_depth  out  $clog2(RS+1)  current stack occupancy
rs_ovf  out  1  sticky: push attempted while stack full
rs_unf  out  1  sticky: pop attempted while stack empty

Behaviour:
- Reset (async assert on Reset_n=0, sync release):
  - pc=0, halted=0, rs_depth=0, rs_ovf=0, rs_unf=0.
  - Every table entry = {rel=0, target=0}.
- All state updates occur on the rising Clk edge. pc is a register output (no combinational path from inputs to pc). A new pc is visible 1 cycle after its controls are sampled.
- Target resolution, using the pre-edge pc:
  - entry.rel=0: tgt = entry.target.
  - entry.rel=1: tgt = (pc + entry.target) mod 2**D.
- Sequential next PC = (pc + 1) mod 2**D. 2**D-1 wraps to 0.
- Next-pc priority, highest first:
  - 1. halted=1 or halt_req=1: hold pc; halted<=1; no stack/flag change.
  - 2. stall=1: hold pc; no push/pop.
  - 3. ret=1: stack non-empty: pc<=top, depth-1. Stack empty: pc<=pc+1, rs_unf<=1. jump/call are ignored in that cycle.
  - 4. call=1: pc<=tgt. Stack not full: push pc+1, depth+1. Stack full: no push, rs_ovf<=1, jump still taken.
  - 5. jump=1: pc<=tgt.
  - 6. otherwise: pc<=pc+1.
- Table writes:
  - Accepted whenever wr_en=1, including during stall or halt.
  - Write occurs at the edge.
  - A lookup of the same index in the same cycle sees the OLD entry; the new entry is visible from the next cycle.
- Stack is LIFO; rs_depth saturates in the range 0..RS. Sticky flags clear only on reset.
- Reset mid-operation: all of the above return to reset values immediately. Table contents are lost.
- The stack pointer is D-independent. Pushed values are D bits wide, with the wrap already applied, so a push at pc=2**D-1 stores 0.

Decomposition:
- Package pc_pkg holds:
  - defaults PC_W=12, IDX_W=5, RS_DEPTH=4;
  - typedef jt_entry_t {logic rel; logic [PC_W-1:0] target};
  - enum next_sel_t {SEL_HOLD, SEL_RET, SEL_TGT, SEL_INC}.
- One sub-module, ret_stack:
  - parameters RS and D;
  - push/pop/data/top/depth/full/empty ports;
  - owns the overflow/underflow sticky logic.
- pc_seq holds the table array, target adder, priority mux and PC register.

Test Plan:
- Reset then 5 idle cycles -> pc = 0,1,2,3,4. Release with stall=1 -> pc stays 0. Force pc=2**D-1 via an abs entry -> next cycle pc=0.
- Write idx1={rel=1,'hFFB}. At pc=4 assert jump, addr=1 -> pc='hFFF. Write idx0={rel=0,21}, jump addr=0 -> pc=21. Write idx2={rel=1,'hFFF} at pc=4 -> pc=3.
- Same-cycle write idx3={0,100} and jump addr=3 (old entry {0,0}) -> pc=0. Jump addr=3 next -> pc=100.
- call at pc=10 to abs 50 -> pc=50, depth=1. ret -> pc=11, depth=0. ret again -> pc=12, rs_unf=1.
- 5 nested calls with RS=4 -> 5th jumps but does not push, rs_ovf=1, depth=4. 4 rets pop the stored returns in LIFO order.
- halt_req at pc=7 -> pc stays 7, halted=1. Later jump/call/ret have no effect; a table write during halt still lands. Reset_n=0 mid-run -> pc=0, flags=0 asynchronously.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   PC_W     - default PC / jump-target width
//   IDX_W    - default jump-table index width (table depth = 2**IDX_W)
//   RS_DEPTH - default return-stack depth
//   jt_entry_t - one jump-table entry at the default width
//   next_sel_t - source of the next PC value
package pc_pkg;

    localparam int PC_W     = 12;
    localparam int IDX_W    = 5;
    localparam int RS_DEPTH = 4;

    typedef struct packed {
        logic            rel;     // 1 = target is an offset from the current pc
        logic [PC_W-1:0] target;  // absolute address or two's-complement offset
    } jt_entry_t;

    typedef enum logic [1:0] {
        SEL_HOLD,  // keep the current pc
        SEL_RET,   // load the top of the return stack
        SEL_TGT,   // load the resolved jump-table target
        SEL_INC    // sequential pc + 1
    } next_sel_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses for call/ret.
//   Clk, Reset_n - rising-edge clock, asynchronous active-low reset
//   push, data   - push data when not full; a push while full sets ovf
//   pop          - drop the top entry when not empty; a pop while empty sets unf
//   top          - current top-of-stack value (0 when empty)
//   depth        - occupancy, 0..RS
//   full, empty  - occupancy status
//   ovf, unf     - sticky overflow / underflow, cleared only by reset
// pop takes precedence if both strobes are raised together.
module ret_stack
    import pc_pkg::*;
#(
    parameter int RS = RS_DEPTH,
    parameter int D  = PC_W
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [D-1:0]             data,
    output logic [D-1:0]             top,
    output logic [$clog2(RS+1)-1:0]  depth,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int DW = $clog2(RS+1);
    localparam int PW = (RS > 1) ? $clog2(RS) : 1;

    logic [D-1:0]  mem [RS];
    logic [DW-1:0] depth_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign full   = (depth_q == DW'(RS));
    assign empty  = (depth_q == '0);
    assign depth  = depth_q;
    assign wr_ptr = PW'(depth_q);
    assign rd_ptr = PW'(depth_q - DW'(1));
    assign top    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            depth_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (pop) begin
            if (empty) unf     <= 1'b1;
            else       depth_q <= depth_q - DW'(1);
        end else if (push) begin
            if (full)  ovf     <= 1'b1;
            else       depth_q <= depth_q + DW'(1);
        end
    end

    // NOTE: the storage array has no reset; depth_q alone decides which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge Clk) begin
        if (push && !pop && !full) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with a writable jump-target table,
// call/return stack, stall and sticky halt.
//   Clk, Reset_n        - rising-edge clock, asynchronous active-low reset
//   stall               - hold pc and stack this cycle
//   halt_req            - stop sequencing; halted stays set until reset
//   jump, call, ret     - control strobes (ret > call > jump)
//   addr                - table index for jump/call
//   wr_en, wr_addr,
//   wr_target, wr_rel   - table write port (always accepted)
//   pc                  - current program counter (registered)
//   halted              - halt latched
//   rs_depth            - return-stack occupancy
//   rs_ovf, rs_unf      - sticky stack overflow / underflow
module pc_seq
    import pc_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int A  = IDX_W,
    parameter int RS = RS_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     stall,
    input  logic                     halt_req,
    input  logic                     jump,
    input  logic                     call,
    input  logic                     ret,
    input  logic [A-1:0]             addr,
    input  logic                     wr_en,
    input  logic [A-1:0]             wr_addr,
    input  logic [D-1:0]             wr_target,
    input  logic                     wr_rel,
    output logic [D-1:0]             pc,
    output logic                     halted,
    output logic [$clog2(RS+1)-1:0]  rs_depth,
    output logic                     rs_ovf,
    output logic                     rs_unf
);

    // Same layout as jt_entry_t, but sized by this instance's D.
    typedef struct packed {
        logic         rel;
        logic [D-1:0] target;
    } entry_t;

    localparam int DEPTH = 2**A;

    entry_t       table_q [DEPTH];
    entry_t       entry;
    logic [D-1:0] pc_q;
    logic [D-1:0] pc_inc;
    logic [D-1:0] tgt;
    logic [D-1:0] pc_next;
    logic         halted_q;
    next_sel_t    sel;

    logic         rs_push;
    logic         rs_pop;
    logic [D-1:0] rs_top;
    logic         rs_full;
    logic         rs_empty;
    logic         unused_rs_full;

    // The stack flags overflow itself, so full is not needed here.
    assign unused_rs_full = rs_full;

    // Lookup reads the registered table, so a same-cycle write is not seen.
    assign entry  = table_q[addr];
    assign pc_inc = pc_q + D'(1);
    assign tgt    = entry.rel ? (pc_q + entry.target) : entry.target;

    // Priority decode: halt > stall > ret > call > jump > increment.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if-chain can leave a latch behind.
        sel     = SEL_INC;
        rs_push = 1'b0;
        rs_pop  = 1'b0;
        if (halted_q || halt_req) begin
            sel = SEL_HOLD;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            rs_pop = 1'b1;
            sel    = rs_empty ? SEL_INC : SEL_RET;
        end else if (call) begin
            rs_push = 1'b1;  // overflowing call still jumps
            sel     = SEL_TGT;
        end else if (jump) begin
            sel = SEL_TGT;
        end
    end

    always_comb begin
        pc_next = pc_inc;
        case (sel)
            SEL_HOLD: pc_next = pc_q;
            SEL_RET:  pc_next = rs_top;
            SEL_TGT:  pc_next = tgt;
            SEL_INC:  pc_next = pc_inc;
            default:  pc_next = pc_inc;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            halted_q <= halted_q | halt_req;
        end
    end

    // Table contents must read as {abs, 0} after reset, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_addr] <= '{rel: wr_rel, target: wr_target};
        end
    end

    ret_stack #(.RS(RS), .D(D)) u_stack (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (rs_push),
        .pop     (rs_pop),
        .data    (pc_inc),
        .top     (rs_top),
        .depth   (rs_depth),
        .full    (rs_full),
        .empty   (rs_empty),
        .ovf     (rs_ovf),
        .unf     (rs_unf)
    );

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed and randomized check of pc_seq against a queue-based
// behavioural model of the sequencer.
module tb_pc_seq;
    import pc_pkg::*;

    localparam int D  = PC_W;
    localparam int A  = IDX_W;
    localparam int RS = RS_DEPTH;
    localparam int N  = 1 << D;
    localparam int DW = $clog2(RS+1);

    logic          Clk;
    logic          Reset_n;
    logic          stall, halt_req, jump, call, ret;
    logic [A-1:0]  addr;
    logic          wr_en;
    logic [A-1:0]  wr_addr;
    logic [D-1:0]  wr_target;
    logic          wr_rel;
    logic [D-1:0]  pc;
    logic          halted;
    logic [DW-1:0] rs_depth;
    logic          rs_ovf, rs_unf;

    pc_seq #(.D(D), .A(A), .RS(RS)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .stall     (stall),
        .halt_req  (halt_req),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .addr      (addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_target (wr_target),
        .wr_rel    (wr_rel),
        .pc        (pc),
        .halted    (halted),
        .rs_depth  (rs_depth),
        .rs_ovf    (rs_ovf),
        .rs_unf    (rs_unf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model
    int        m_pc;
    bit        m_halted, m_ovf, m_unf;
    int        m_stack[$];
    jt_entry_t m_tbl [1<<A];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},     int'(pc),       m_pc);
        check({tag, ".halted"}, int'(halted),   int'(m_halted));
        check({tag, ".depth"},  int'(rs_depth), m_stack.size());
        check({tag, ".ovf"},    int'(rs_ovf),   int'(m_ovf));
        check({tag, ".unf"},    int'(rs_unf),   int'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
        foreach (m_tbl[i]) m_tbl[i] = '0;
    endtask

    // One clock edge of the sequencer, from the currently driven inputs.
    task automatic model_step();
        jt_entry_t e;
        int        tgt;
        e   = m_tbl[addr];
        tgt = e.rel ? (m_pc + int'(e.target)) % N : int'(e.target);
        if (m_halted || halt_req) begin
            m_halted = 1;
        end else if (stall) begin
            // hold
        end else if (ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = (m_pc + 1) % N; m_unf = 1; end
        end else if (call) begin
            if (m_stack.size() < RS) m_stack.push_back((m_pc + 1) % N);
            else m_ovf = 1;
            m_pc = tgt;
        end else if (jump) begin
            m_pc = tgt;
        end else begin
            m_pc = (m_pc + 1) % N;
        end
        if (wr_en) m_tbl[wr_addr] = {wr_rel, wr_target};
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        stall = 0; halt_req = 0; jump = 0; call = 0; ret = 0;
        addr = '0; wr_en = 0; wr_addr = '0; wr_target = '0; wr_rel = 0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("rst_pc_lit", int'(pc), 0);
        check("rst_halted_lit", int'(halted), 0);
        check("rst_flags_lit", int'({rs_ovf, rs_unf}), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle();
    endtask

    // Table write while stalled, so pc does not move.
    task automatic wr(input int idx, input bit rel, input int tgt);
        idle();
        stall = 1; wr_en = 1; wr_addr = A'(idx); wr_rel = rel; wr_target = D'(tgt);
        cycle("wr");
        idle();
    endtask

    task automatic ctl(input string tag, input int idx, input bit j, input bit c, input bit r);
        idle();
        addr = A'(idx); jump = j; call = c; ret = r;
        cycle(tag);
        idle();
    endtask

    localparam int RET_EXP [4] = '{43, 33, 23, 13};

    initial begin
        idle();
        Reset_n = 1'b0;
        do_reset();

        // Sequential counting
        for (int k = 1; k <= 4; k++) begin
            cycle("idle");
            check("idle_pc_lit", int'(pc), k);
        end

        // Stall holds, relative targets and wrap
        wr(1, 1, 'hFFB);
        check("stall_pc_lit", int'(pc), 4);
        ctl("jrel", 1, 1, 0, 0);
        check("jrel_pc_lit", int'(pc), 'hFFF);
        cycle("wrap");
        check("wrap_pc_lit", int'(pc), 0);
        wr(0, 0, 21);
        ctl("jabs", 0, 1, 0, 0);
        check("jabs_pc_lit", int'(pc), 21);
        wr(5, 0, 4);
        ctl("j4", 5, 1, 0, 0);
        wr(2, 1, 'hFFF);
        ctl("jneg", 2, 1, 0, 0);
        check("jneg_pc_lit", int'(pc), 3);

        // Same-cycle write and lookup sees the old entry
        idle();
        jump = 1; addr = 3; wr_en = 1; wr_addr = 3; wr_rel = 0; wr_target = 100;
        cycle("wr_same");
        idle();
        check("wr_same_pc_lit", int'(pc), 0);
        ctl("wr_new", 3, 1, 0, 0);
        check("wr_new_pc_lit", int'(pc), 100);

        // Call / return / underflow
        wr(6, 0, 10);
        ctl("j10", 6, 1, 0, 0);
        wr(7, 0, 50);
        ctl("call", 7, 0, 1, 0);
        check("call_pc_lit", int'(pc), 50);
        check("call_depth_lit", int'(rs_depth), 1);
        ctl("ret", 0, 0, 0, 1);
        check("ret_pc_lit", int'(pc), 11);
        check("ret_depth_lit", int'(rs_depth), 0);
        ctl("ret_unf", 0, 0, 0, 1);
        check("unf_pc_lit", int'(pc), 12);
        check("unf_flag_lit", int'(rs_unf), 1);

        // Nested calls with overflow, LIFO returns
        wr(8, 1, 10);
        for (int k = 1; k <= 5; k++) begin
            ctl("ncall", 8, 0, 1, 0);
            check("ncall_pc_lit", int'(pc), 12 + 10 * k);
            check("ncall_depth_lit", int'(rs_depth), (k < RS) ? k : RS);
        end
        check("ovf_flag_lit", int'(rs_ovf), 1);
        for (int k = 0; k < 4; k++) begin
            ctl("nret", 0, 0, 0, 1);
            check("nret_pc_lit", int'(pc), RET_EXP[k]);
        end

        // Halt
        wr(9, 0, 7);
        ctl("j7", 9, 1, 0, 0);
        idle();
        halt_req = 1;
        cycle("halt");
        idle();
        check("halt_pc_lit", int'(pc), 7);
        check("halt_flag_lit", int'(halted), 1);
        for (int k = 0; k < 6; k++) begin
            addr = A'(k); jump = (k % 3 == 0); call = (k % 3 == 1); ret = (k % 3 == 2);
            wr_en = 1; wr_addr = A'(k + 9); wr_target = D'(200 + k);
            cycle("halted");
            check("halted_pc_lit", int'(pc), 7);
        end
        idle();

        // Asynchronous reset mid-run
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                stall     = ($urandom_range(0, 7) == 0);
                halt_req  = ($urandom_range(0, 499) == 0);
                jump      = ($urandom_range(0, 3) == 0);
                call      = ($urandom_range(0, 5) == 0);
                ret       = ($urandom_range(0, 5) == 0);
                addr      = A'($urandom_range(0, (1 << A) - 1));
                wr_en     = ($urandom_range(0, 2) == 0);
                wr_addr   = A'($urandom_range(0, (1 << A) - 1));
                wr_target = D'($urandom_range(0, N - 1));
                wr_rel    = ($urandom_range(0, 1) == 1);
                cycle("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
